dual_gray_updn_cntr: RTL
========================

DUAL_GRAY_UPDN_CNTR -- requirements
Module: dual_gray_updn_cntr

Interface
REQ-001 Parameter: width, default 1, counter width in bits; legal range 1..32.
REQ-002 Parameter: init, default all-zero, binary reset value.
REQ-003 Parameter: sat, default 0; 0 = wrap at the ends of the range, 1 = saturate at the ends.
REQ-004 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: RST  input  1  asynchronous, active-low reset.
REQ-006 Port: INCR  input  1  count-up request.
REQ-007 Port: DECR  input  1  count-down request.
REQ-008 Port: LOAD  input  1  synchronous load request.
REQ-009 Port: LOAD_VAL  input  width  binary value to load.
REQ-010 Port: B_OUT  output  width  registered binary count.
REQ-011 Port: G_OUT  output  width  registered Gray count, always equal to B_OUT ^ (B_OUT >> 1).
REQ-012 Port: AT_MAX  output  1  registered; high when B_OUT is all ones.
REQ-013 Port: AT_MIN  output  1  registered; high when B_OUT is all zeros.
REQ-014 Port: WRAP  output  1  registered one-cycle pulse after a wrap-around step.

Function
REQ-015 Priority per edge: LOAD, then exactly one of INCR/DECR, then hold.
- LOAD=1: B <= LOAD_VAL; G <= gray(LOAD_VAL); INCR and DECR are ignored.
REQ-016 INCR=1 with DECR=0 and LOAD=0: B <= B+1 modulo 2^width.
REQ-017 DECR=1 with INCR=0 and LOAD=0: B <= B-1 modulo 2^width.
REQ-018 INCR=1 with DECR=1 and LOAD=0: hold; no output changes; WRAP=0.
REQ-019 Latency: B_OUT, G_OUT, AT_MAX, AT_MIN and WRAP reflect a request one edge after it is sampled; no combinational path from inputs to outputs.
REQ-020 Gray next value is computed from the next binary value and registered in the same edge as B; B_OUT and G_OUT never disagree on any cycle.
REQ-021 For any single INCR or DECR step, G_OUT changes in exactly one bit; LOAD may change any number of bits.
REQ-022 sat=0, up-step at all ones: B <= 0 and WRAP pulses 1 for one cycle.
REQ-023 sat=0, down-step at zero: B <= all ones and WRAP pulses 1 for one cycle.
REQ-024 sat=1, up-step at all ones or down-step at zero: hold; G_OUT unchanged; WRAP stays 0.
REQ-025 WRAP is 0 on every cycle not immediately following a wrap step, including LOAD cycles.
REQ-026 width=1 is legal: the count toggles 0<->1, G_OUT equals B_OUT, and AT_MAX/AT_MIN are mutually exclusive.

Reset
REQ-027 RST low asynchronously forces B_OUT=init, G_OUT=gray(init), WRAP=0, and AT_MAX/AT_MIN as derived from init, without waiting for CLK.
REQ-028 While RST is low, INCR, DECR and LOAD are ignored.
REQ-029 First update after release: on the first rising CLK edge with RST high.
REQ-030 Reset asserted mid-count discards the pending request, with no partial update.
REQ-031 Under simulation only, without BSV_NO_INITIAL_BLOCKS: registers start at the alternating 10 pattern; an error is displayed and $finish is called if width < 1.

Configuration
REQ-032 Macro BSV_GRAY_CNTR_ERRCHK_EN defined: the block adds output port ERR (1 bit, registered).
- ERR is set high on the edge after G_OUT != gray(B_OUT) is detected (e.g. an SEU or a forced value).
- ERR is sticky until RST is asserted.
- ERR resets to 0.
REQ-033 Macro BSV_GRAY_CNTR_ERRCHK_EN undefined: there is no ERR port, no checker logic, and behaviour is otherwise identical.

Verification
REQ-034 width=4, init=0, sat=0; release reset; hold INCR=1 for 17 cycles -> B_OUT 0..15,0,1; WRAP high exactly once, on the cycle B_OUT=0 after 15; G_OUT has one-bit changes throughout.
REQ-035 width=4, sat=0, B=0; DECR=1 for one cycle -> B_OUT=15, G_OUT=4'b1000, AT_MAX=1, WRAP=1 for one cycle.
REQ-036 width=4, sat=1, B=15; INCR=1 for 3 cycles -> B_OUT stays 15, G_OUT stays 4'b1000, WRAP=0; then DECR from 0 -> B_OUT stays 0.
REQ-037 Same edge LOAD=1, LOAD_VAL=9, INCR=1 -> B_OUT=9, G_OUT=4'b1101; then INCR=1 with DECR=1 for 5 cycles -> B_OUT stays 9.
REQ-038 init=5; count to B=12; assert RST low between CLK edges -> B_OUT=5 and G_OUT=4'b0111 immediately; outputs hold until RST returns high.
REQ-039 With BSV_GRAY_CNTR_ERRCHK_EN, force G_reg bit 0 for one cycle -> ERR=1 on the next edge; ERR remains 1 until RST is pulsed low.

Source files
------------

// File: rtl/dual_gray_updn_cntr.sv
// Binary/Gray up-down counter with optional wrap or saturation at the range ends.
// Define BSV_GRAY_CNTR_ERRCHK_EN to add the sticky Gray/binary consistency checker (ERR).
module dual_gray_updn_cntr #(
    parameter int unsigned     width = 1,
    parameter logic [width-1:0] init = '0,
    parameter bit              sat   = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INCR,
    input  logic             DECR,
    input  logic             LOAD,
    input  logic [width-1:0] LOAD_VAL,
    output logic [width-1:0] B_OUT,
    output logic [width-1:0] G_OUT,
    output logic             AT_MAX,
    output logic             AT_MIN,
    output logic             WRAP
`ifdef BSV_GRAY_CNTR_ERRCHK_EN
    ,
    output logic             ERR
`endif
);

    localparam logic [width-1:0] ALL_ONES = '1;
    localparam logic [width-1:0] ALL_ZERO = '0;

    function automatic logic [width-1:0] to_gray(input logic [width-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [width-1:0] b_nxt;
    logic             wrap_nxt;

    // Next binary value: load beats a single-direction step; both or neither holds.
    always_comb begin
        b_nxt    = B_OUT;
        wrap_nxt = 1'b0;
        if (LOAD) begin
            b_nxt = LOAD_VAL;
        end else if (INCR && !DECR) begin
            if (B_OUT == ALL_ONES) begin
                if (!sat) begin
                    b_nxt    = ALL_ZERO;
                    wrap_nxt = 1'b1;
                end
            end else begin
                b_nxt = B_OUT + width'(1);
            end
        end else if (DECR && !INCR) begin
            if (B_OUT == ALL_ZERO) begin
                if (!sat) begin
                    b_nxt    = ALL_ONES;
                    wrap_nxt = 1'b1;
                end
            end else begin
                b_nxt = B_OUT - width'(1);
            end
        end
    end

    // Gray and flags are derived from the same next value so they never disagree with B_OUT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            B_OUT  <= init;
            G_OUT  <= to_gray(init);
            AT_MAX <= (init == ALL_ONES);
            AT_MIN <= (init == ALL_ZERO);
            WRAP   <= 1'b0;
        end else begin
            B_OUT  <= b_nxt;
            G_OUT  <= to_gray(b_nxt);
            AT_MAX <= (b_nxt == ALL_ONES);
            AT_MIN <= (b_nxt == ALL_ZERO);
            WRAP   <= wrap_nxt;
        end
    end

`ifdef BSV_GRAY_CNTR_ERRCHK_EN
    // Sticky flag for a Gray register that no longer matches the binary register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ERR <= 1'b0;
        end else if (G_OUT != to_gray(B_OUT)) begin
            ERR <= 1'b1;
        end
    end
`endif

endmodule
